// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - 8N1 UART receiver with mid-bit sampling and a ready/clear handshake
//
// Purpose:
//    Receives 1 start bit, 8 data bits (LSB first) and 1 stop bit from an
//    asynchronous serial line. The line is synchronized through two flops,
//    a falling edge starts a frame, and every bit is sampled near its middle
//    using a down-counting baud counter.
//
// Optional feature:
//    UART_RX_FRAME_ERR_EN - when defined, a low stop bit drops the byte and
//    pulses frame_err for one cycle. When undefined, frame_err is tied low
//    and the stop bit is not checked.
//
// Parameters:
//    BAUD_CNT   clk cycles per bit (4 .. 65535)
//
// Ports:
//    clk        system clock, rising edge
//    rst        synchronous active-high reset
//    RX         asynchronous serial input, idles high
//    clr_rdy    one-cycle strobe from the consumer, clears rdy
//    rx_data    most recently received good byte
//    rdy        high while rx_data holds an unconsumed byte
//    frame_err  one-cycle pulse on a bad stop bit (feature-dependent)

`timescale 1ns/1ps

module uart_rx #(
   parameter int BAUD_CNT = 2604
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       RX,
   input  logic       clr_rdy,
   output logic [7:0] rx_data,
   output logic       rdy,
   output logic       frame_err
);

   // First reload lands the start-bit sample mid-bit; later reloads step one
   // full bit period (expiry itself is the extra cycle).
   localparam logic [15:0] HALF_CNT   = 16'(BAUD_CNT / 2);
   localparam logic [15:0] RELOAD_CNT = 16'(BAUD_CNT - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } state_t;

   state_t      state;
   state_t      state_nxt;

   logic        rx_meta;
   logic        rx_s;
   logic        rx_prev;
   logic [15:0] baud_cnt;
   logic [3:0]  bit_cnt;
   logic [7:0]  shift_reg;

   logic        expiry;
   logic        rx_fall;

   // Control strobes decoded from the FSM
   logic        start_frame;
   logic        start_ok;
   logic        sample_bit;
   logic        load_byte;

   assign expiry  = (baud_cnt == 16'd0);
   // Needs a high-then-low pair so a line stuck low never starts a frame.
   assign rx_fall = rx_prev & ~rx_s;

   // ------------------------------------------------------------------
   // Input synchronizer; rx_prev supplies the edge detector's history.
   // ------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         rx_meta <= 1'b1;
         rx_s    <= 1'b1;
         rx_prev <= 1'b1;
      end else begin
         rx_meta <= RX;
         rx_s    <= rx_meta;
         rx_prev <= rx_s;
      end
   end

   // ------------------------------------------------------------------
   // FSM: state register
   // ------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // ------------------------------------------------------------------
   // FSM: next-state logic
   // ------------------------------------------------------------------
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (rx_fall) begin
               state_nxt = START;
            end
         end
         START: begin
            // A line back high at mid start bit was a glitch.
            if (expiry) begin
               state_nxt = rx_s ? IDLE : DATA;
            end
         end
         DATA: begin
            if (expiry && (bit_cnt == 4'd7)) begin
               state_nxt = STOP;
            end
         end
         STOP: begin
            // Leaving at mid stop bit leaves half a bit of slack for the
            // next start edge in a back-to-back stream.
            if (expiry) begin
               state_nxt = IDLE;
            end
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   // ------------------------------------------------------------------
   // FSM: output decode
   // ------------------------------------------------------------------
   always_comb begin
      start_frame = 1'b0;
      start_ok    = 1'b0;
      sample_bit  = 1'b0;
      load_byte   = 1'b0;
      case (state)
         IDLE:  start_frame = rx_fall;
         START: start_ok    = expiry & ~rx_s;
         DATA:  sample_bit  = expiry;
`ifdef UART_RX_FRAME_ERR_EN
         STOP:  load_byte   = expiry & rx_s;
`else
         STOP:  load_byte   = expiry;
`endif
         default: begin
            start_frame = 1'b0;
         end
      endcase
   end

   // ------------------------------------------------------------------
   // Baud counter: loaded at the start edge, free-runs while in a frame.
   // ------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         baud_cnt <= 16'd0;
      end else if (start_frame) begin
         baud_cnt <= HALF_CNT;
      end else if (state != IDLE) begin
         if (expiry) begin
            baud_cnt <= RELOAD_CNT;
         end else begin
            baud_cnt <= baud_cnt - 16'd1;
         end
      end
   end

   // ------------------------------------------------------------------
   // Bit counter and shift register (LSB arrives first, shifts right).
   // ------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         bit_cnt   <= 4'd0;
         shift_reg <= 8'h00;
      end else if (start_ok) begin
         bit_cnt <= 4'd0;
      end else if (sample_bit) begin
         bit_cnt   <= bit_cnt + 4'd1;
         shift_reg <= {rx_s, shift_reg[7:1]};
      end
   end

   // ------------------------------------------------------------------
   // Output byte and ready flag. A completing frame beats a coincident
   // clear so a byte is never lost to a late clr_rdy.
   // ------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         rx_data <= 8'h00;
      end else if (load_byte) begin
         rx_data <= shift_reg;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rdy <= 1'b0;
      end else if (load_byte) begin
         rdy <= 1'b1;
      end else if (start_frame || clr_rdy) begin
         rdy <= 1'b0;
      end
   end

   // ------------------------------------------------------------------
   // Framing error pulse
   // ------------------------------------------------------------------
`ifdef UART_RX_FRAME_ERR_EN
   logic stop_bad;

   assign stop_bad = (state == STOP) & expiry & ~rx_s;

   always_ff @(posedge clk) begin
      if (rst) begin
         frame_err <= 1'b0;
      end else begin
         frame_err <= stop_bad;
      end
   end
`else
   assign frame_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - directed self-checking bench for uart_rx

`timescale 1ns/1ps

module tb_uart_rx;

   localparam int B = 16;

   logic       clk;
   logic       rst;
   logic       RX;
   logic       clr_rdy;
   logic [7:0] rx_data;
   logic       rdy;
   logic       frame_err;

   int n_cmp = 0;
   int n_bad = 0;

   // Per-frame observations filled in by send_frame
   int         clr_at = -1;
   int         rst_at = -1;
   int         rise_at;
   int         clr_seen;
   int         err_cnt;
   int         err_run;
   int         err_maxw;
   logic       rst_rdy;
   logic       rst_err;
   logic [7:0] rst_data;

   uart_rx #(.BAUD_CNT(B)) dut (
      .clk       (clk),
      .rst       (rst),
      .RX        (RX),
      .clr_rdy   (clr_rdy),
      .rx_data   (rx_data),
      .rdy       (rdy),
      .frame_err (frame_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Drives one 10-bit frame, B cycles per bit. Cycle numbers recorded are
   // counted in rising edges after the start-bit falling edge (first = 1).
   // RX is left at the stop-bit level so frames can be chained.
   task automatic send_frame(input logic [7:0] d, input logic stop);
      logic [9:0] bits;
      logic       was_rdy;
      bits     = {stop, d, 1'b0};
      rise_at  = -1;
      clr_seen = -1;
      err_cnt  = 0;
      err_run  = 0;
      err_maxw = 0;
      was_rdy  = rdy;
      for (int c = 0; c < 10 * B; c++) begin
         @(negedge clk);
         RX      = bits[c / B];
         clr_rdy = (c == clr_at);
         rst     = (c == rst_at);
         @(posedge clk);
         #1;
         if (rdy && !was_rdy && rise_at < 0) rise_at = c + 1;
         if (!rdy && was_rdy && clr_seen < 0) clr_seen = c + 1;
         was_rdy = rdy;
         if (frame_err) begin
            err_cnt++;
            err_run++;
            if (err_run > err_maxw) err_maxw = err_run;
         end else begin
            err_run = 0;
         end
         if (c == rst_at) begin
            rst_rdy  = rdy;
            rst_err  = frame_err;
            rst_data = rx_data;
         end
      end
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(negedge clk);
         clr_rdy = 1'b0;
         rst     = 1'b0;
      end
   endtask

   task automatic test_reset();
      rst     = 1'b1;
      RX      = 1'b1;
      clr_rdy = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      n_cmp++;
      if (rdy !== 1'b0) begin
         n_bad++;
         $display("FAIL reset_rdy: got %b want 0", rdy);
      end
      n_cmp++;
      if (frame_err !== 1'b0) begin
         n_bad++;
         $display("FAIL reset_frame_err: got %b want 0", frame_err);
      end
      n_cmp++;
      if (rx_data !== 8'h00) begin
         n_bad++;
         $display("FAIL reset_rx_data: got %h want 00", rx_data);
      end
      idle(4);
   endtask

   task automatic test_basic();
      send_frame(8'hA5, 1'b1);
      n_cmp++;
      if (rise_at < 154 || rise_at > 156) begin
         n_bad++;
         $display("FAIL basic_latency: got %0d want 154..156", rise_at);
      end
      n_cmp++;
      if (rx_data !== 8'hA5) begin
         n_bad++;
         $display("FAIL basic_data: got %h want a5", rx_data);
      end
      n_cmp++;
      if (rdy !== 1'b1) begin
         n_bad++;
         $display("FAIL basic_rdy: got %b want 1", rdy);
      end
      n_cmp++;
      if (err_cnt != 0) begin
         n_bad++;
         $display("FAIL basic_frame_err: got %0d pulses want 0", err_cnt);
      end
      idle(B);
   endtask

   task automatic test_back_to_back();
      send_frame(8'h3C, 1'b1);
      n_cmp++;
      if (rx_data !== 8'h3C || rdy !== 1'b1) begin
         n_bad++;
         $display("FAIL b2b_first: got data %h rdy %b want 3c 1", rx_data, rdy);
      end
      send_frame(8'hC3, 1'b1);
      n_cmp++;
      if (clr_seen < 2 || clr_seen > 4) begin
         n_bad++;
         $display("FAIL b2b_rdy_clear: got cycle %0d want 2..4", clr_seen);
      end
      n_cmp++;
      if (rise_at < 154 || rise_at > 156) begin
         n_bad++;
         $display("FAIL b2b_latency: got %0d want 154..156", rise_at);
      end
      n_cmp++;
      if (rx_data !== 8'hC3 || rdy !== 1'b1) begin
         n_bad++;
         $display("FAIL b2b_second: got data %h rdy %b want c3 1", rx_data, rdy);
      end
      idle(B);
   endtask

   task automatic test_glitch();
      int errs;
      logic saw_rdy;
      errs    = 0;
      saw_rdy = 1'b0;
      @(negedge clk);
      clr_rdy = 1'b1;
      @(negedge clk);
      clr_rdy = 1'b0;
      RX      = 1'b0;
      repeat (4) @(negedge clk);
      RX = 1'b1;
      repeat (3 * B) begin
         @(posedge clk);
         #1;
         if (frame_err) errs++;
         if (rdy) saw_rdy = 1'b1;
      end
      n_cmp++;
      if (saw_rdy !== 1'b0 || rx_data !== 8'hC3) begin
         n_bad++;
         $display("FAIL glitch_outputs: got rdy_seen %b data %h want 0 c3", saw_rdy, rx_data);
      end
      n_cmp++;
      if (errs != 0) begin
         n_bad++;
         $display("FAIL glitch_frame_err: got %0d pulses want 0", errs);
      end
      idle(2);
      send_frame(8'h5A, 1'b1);
      n_cmp++;
      if (rx_data !== 8'h5A || rdy !== 1'b1) begin
         n_bad++;
         $display("FAIL glitch_recover: got data %h rdy %b want 5a 1", rx_data, rdy);
      end
      idle(B);
   endtask

   task automatic test_frame_err();
      logic [7:0] exp_data;
      logic       exp_rdy;
      int         exp_err;
      int         errs;
      send_frame(8'h55, 1'b0);
`ifdef UART_RX_FRAME_ERR_EN
      exp_data = 8'h5A;
      exp_rdy  = 1'b0;
      exp_err  = 1;
      n_cmp++;
      if (err_maxw != 1) begin
         n_bad++;
         $display("FAIL ferr_pulse_width: got %0d want 1", err_maxw);
      end
`else
      exp_data = 8'h55;
      exp_rdy  = 1'b1;
      exp_err  = 0;
`endif
      n_cmp++;
      if (err_cnt != exp_err) begin
         n_bad++;
         $display("FAIL ferr_count: got %0d want %0d", err_cnt, exp_err);
      end
      n_cmp++;
      if (rdy !== exp_rdy || rx_data !== exp_data) begin
         n_bad++;
         $display("FAIL ferr_outputs: got rdy %b data %h want %b %h", rdy, rx_data, exp_rdy, exp_data);
      end
      // Line stays low well past a frame length: no frame may start.
      errs = 0;
      repeat (12 * B) begin
         @(posedge clk);
         #1;
         if (frame_err) errs++;
      end
      n_cmp++;
      if (errs != 0 || rdy !== exp_rdy || rx_data !== exp_data) begin
         n_bad++;
         $display("FAIL held_low: got errs %0d rdy %b data %h want 0 %b %h", errs, rdy, rx_data, exp_rdy, exp_data);
      end
      @(negedge clk);
      RX = 1'b1;
      idle(2 * B);
   endtask

   task automatic test_clr_rdy();
      clr_at = 155;
      send_frame(8'h96, 1'b1);
      clr_at = -1;
      n_cmp++;
      if (rdy !== 1'b1 || rx_data !== 8'h96) begin
         n_bad++;
         $display("FAIL clr_coincident: got rdy %b data %h want 1 96", rdy, rx_data);
      end
      clr_at = 156;
      send_frame(8'h69, 1'b1);
      clr_at = -1;
      n_cmp++;
      if (rise_at != 156) begin
         n_bad++;
         $display("FAIL clr_late_rise: got cycle %0d want 156", rise_at);
      end
      n_cmp++;
      if (rdy !== 1'b0 || rx_data !== 8'h69) begin
         n_bad++;
         $display("FAIL clr_late: got rdy %b data %h want 0 69", rdy, rx_data);
      end
      idle(B);
   endtask

   task automatic test_reset_midframe();
      rst_at = 60;
      send_frame(8'hFF, 1'b1);
      rst_at = -1;
      n_cmp++;
      if (rst_rdy !== 1'b0 || rst_err !== 1'b0 || rst_data !== 8'h00) begin
         n_bad++;
         $display("FAIL midrst_outputs: got rdy %b err %b data %h want 0 0 00", rst_rdy, rst_err, rst_data);
      end
      n_cmp++;
      if (rdy !== 1'b0 || rx_data !== 8'h00) begin
         n_bad++;
         $display("FAIL midrst_abandon: got rdy %b data %h want 0 00", rdy, rx_data);
      end
      idle(B);
      send_frame(8'h12, 1'b1);
      n_cmp++;
      if (rx_data !== 8'h12 || rdy !== 1'b1) begin
         n_bad++;
         $display("FAIL midrst_next: got data %h rdy %b want 12 1", rx_data, rdy);
      end
      idle(B);
   endtask

   initial begin
      RX      = 1'b1;
      rst     = 1'b1;
      clr_rdy = 1'b0;
      test_reset();
      test_basic();
      test_back_to_back();
      test_glitch();
      test_frame_err();
      test_clr_rdy();
      test_reset_midframe();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
